// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an incoming PWM waveform and reports its period and active-pulse
//   width in prescaled ticks (same units as the pwm_generator period/pulse
//   inputs). Each completed cycle is reported with a one-cycle strobe, and a
//   line with no edges for TIMEOUT ticks is flagged as stuck.
//
// Parameters
//   PRESCALER : sclk cycles per measurement tick (>= 1)
//   WIDTH     : width of the period/pulse counters and outputs
//   TIMEOUT   : ticks without any input edge before the line is declared stuck (>= 1)
//
// Ports
//   sclk      in   system clock
//   rst       in   synchronous, active-high reset
//   pwm_in    in   PWM input, asynchronous to sclk
//   pwm_mode  in   0: high is active, 1: low is active
//   period    out  last measured period, ticks
//   pulse     out  last measured active width, ticks
//   valid     out  one-cycle strobe when period/pulse update
//   no_signal out  no measurement yet, or line stuck
//   level     out  synchronized pwm_in, raw polarity
module pwm_capture #(
  parameter int PRESCALER = 2,
  parameter int WIDTH     = 26,
  parameter int TIMEOUT   = 2_000_000
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             pwm_mode,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] pulse,
  output logic             valid,
  output logic             no_signal,
  output logic             level
);

  localparam int DIV_W  = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(PRESCALER - 1);
  // The detection cycle itself is elapsed cycle 1 of the new measurement, so
  // the divider restarts at 1 (or, with no division, the first tick is
  // already counted).
  localparam logic [DIV_W-1:0]  DIV_START  = (PRESCALER > 1) ? DIV_W'(1) : DIV_W'(0);
  localparam logic [WIDTH-1:0]  CNT_START  = (PRESCALER > 1) ? WIDTH'(0) : WIDTH'(1);
  localparam logic [WIDTH-1:0]  CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [IDLE_W-1:0] IDLE_LIM   = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_START = (PRESCALER > 1) ? IDLE_W'(0) : IDLE_W'(1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACTIVE   = 2'd1;
  localparam logic [1:0] S_INACTIVE = 2'd2;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + WIDTH'(1);
  endfunction

  function automatic logic [IDLE_W-1:0] idle_inc(input logic [IDLE_W-1:0] v);
    return (v >= IDLE_LIM) ? v : v + IDLE_W'(1);
  endfunction

  logic              r_sync_p0, r_sync_p1, r_sync_p2;
  logic              r_mode_p0, r_mode_p1;
  logic [1:0]        r_warm;
  logic              r_act_edge, r_inact_edge;
  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_pulse_lat;
  logic [DIV_W-1:0]  r_idle_div;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [WIDTH-1:0]  r_period, r_pulse;
  logic              r_valid, r_no_signal;

  logic              w_act_now, w_act_prev, w_warm_ok;
  logic              w_mode_chg, w_any_edge, w_tick, w_idle_tick, w_timeout;
  logic [IDLE_W-1:0] w_idle_next;

  // Active-level mapping uses one mode value for both samples, so a mode
  // change alone never looks like an edge.
  assign w_act_now  = r_sync_p1 ^ r_mode_p0;
  assign w_act_prev = r_sync_p2 ^ r_mode_p0;
  // After reset the synchronizer holds zeros rather than the line value; edge
  // detection waits until the whole chain carries real samples so a line that
  // was high across reset is not mistaken for a fresh edge.
  assign w_warm_ok  = (r_warm == 2'd3);

  // Stage p0..p2: synchronizer and edge-detect register
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_sync_p0    <= 1'b0;
      r_sync_p1    <= 1'b0;
      r_sync_p2    <= 1'b0;
      r_mode_p0    <= 1'b0;
      r_mode_p1    <= 1'b0;
      r_warm       <= 2'd0;
      r_act_edge   <= 1'b0;
      r_inact_edge <= 1'b0;
    end else begin
      r_sync_p0    <= pwm_in;
      r_sync_p1    <= r_sync_p0;
      r_sync_p2    <= r_sync_p1;
      r_mode_p0    <= pwm_mode;
      r_mode_p1    <= r_mode_p0;
      if (!w_warm_ok) r_warm <= r_warm + 2'd1;
      r_act_edge   <= w_warm_ok & w_act_now & ~w_act_prev;
      r_inact_edge <= w_warm_ok & ~w_act_now & w_act_prev;
    end
  end

  assign w_mode_chg  = r_mode_p0 ^ r_mode_p1;
  assign w_any_edge  = r_act_edge | r_inact_edge;
  assign w_tick      = (r_div == DIV_LAST);
  assign w_idle_tick = (r_idle_div == DIV_LAST);
  assign w_idle_next = w_idle_tick ? idle_inc(r_idle_cnt) : r_idle_cnt;
  // An edge in the same cycle always beats the timeout. The timeout stays
  // asserted while the line remains quiet; re-applying it is harmless.
  assign w_timeout   = ~w_any_edge & (w_idle_next >= IDLE_LIM);

  // Stage p3: measurement FSM and output registers
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_cnt       <= '0;
      r_pulse_lat <= '0;
      r_idle_div  <= '0;
      r_idle_cnt  <= '0;
      r_period    <= '0;
      r_pulse     <= '0;
      r_valid     <= 1'b0;
      r_no_signal <= 1'b1;
    end else begin
      r_valid <= 1'b0;

      if (w_any_edge) begin
        r_idle_div <= DIV_START;
        r_idle_cnt <= IDLE_START;
      end else begin
        r_idle_div <= w_idle_tick ? '0 : r_idle_div + 1'b1;
        r_idle_cnt <= w_idle_next;
      end

      if (w_mode_chg) begin
        r_state <= S_IDLE;
      end else if (w_timeout) begin
        r_no_signal <= 1'b1;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_act_edge) begin
              r_div   <= DIV_START;
              r_cnt   <= CNT_START;
              r_state <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (w_tick) begin
              r_div <= '0;
              r_cnt <= sat_inc(r_cnt);
            end else begin
              r_div <= r_div + 1'b1;
            end
            // r_cnt already covers every cycle up to the detection cycle.
            if (r_inact_edge) begin
              r_pulse_lat <= r_cnt;
              r_state     <= S_INACTIVE;
            end
          end
          S_INACTIVE: begin
            if (r_act_edge) begin
              r_period    <= r_cnt;
              r_pulse     <= r_pulse_lat;
              r_valid     <= 1'b1;
              r_no_signal <= 1'b0;
              r_div       <= DIV_START;
              r_cnt       <= CNT_START;
              r_state     <= S_ACTIVE;
            end else if (w_tick) begin
              r_div <= '0;
              r_cnt <= sat_inc(r_cnt);
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign period    = r_period;
  assign pulse     = r_pulse;
  assign valid     = r_valid;
  assign no_signal = r_no_signal;
  assign level     = r_sync_p1;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Drives pwm_capture with scripted and randomized PWM waveforms and compares
//   every published measurement with values computed from the cycle lengths:
//   period = floor(C / PRESCALER), pulse = floor(H / PRESCALER), saturated.
module tb_pwm_capture;

  localparam int P    = 2;
  localparam int W    = 10;
  localparam int TO   = 1200;
  localparam int MAXV = (1 << W) - 1;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic         pwm_mode = 1'b0;
  logic [W-1:0] period, pulse;
  logic         valid, no_signal, level;

  pwm_capture #(.PRESCALER(P), .WIDTH(W), .TIMEOUT(TO)) dut (
    .sclk(sclk), .rst(rst), .pwm_in(pwm_in), .pwm_mode(pwm_mode),
    .period(period), .pulse(pulse), .valid(valid),
    .no_signal(no_signal), .level(level)
  );

  always #5 sclk = ~sclk;

  int   n_chk = 0, n_err = 0;
  int   cyc = 0, act_cyc = 0, n_valid = 0, last_vcyc = 0;
  int   exp_per = 0, exp_pul = 0;
  logic prev_valid = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: ticks from a length in sclk cycles, saturating at 2^W-1.
  function automatic int ticks(input int sclks);
    int t;
    t = sclks / P;
    return (t > MAXV) ? MAXV : t;
  endfunction

  always @(posedge sclk) cyc <= cyc + 1;

  // Every published measurement is compared against the current expectation.
  always @(negedge sclk) begin
    if (valid) begin
      check_val("period", period, exp_per);
      check_val("pulse", pulse, exp_pul);
      check_val("no_signal_at_valid", no_signal, 0);
      check_val("valid_latency", cyc - act_cyc, 4);
      check_val("valid_back_to_back", prev_valid, 0);
      n_valid   <= n_valid + 1;
      last_vcyc <= cyc;
    end
    prev_valid <= valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic drive_cycles(input logic act, input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in  = act;
      act_cyc = cyc;
      tick(h);
      pwm_in  = ~act;
      tick(l);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_period"}, period, 0);
    check_val({tag, "_pulse"}, pulse, 0);
    check_val({tag, "_valid"}, valid, 0);
    check_val({tag, "_no_signal"}, no_signal, 1);
    check_val({tag, "_level"}, level, 0);
  endtask

  task automatic start_phase(input logic mode, input logic act, input int h, input int l);
    pwm_mode = mode;
    pwm_in   = ~act;
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs("rst");
    tick(6);
    exp_per = ticks(h + l);
    exp_pul = ticks(h);
  endtask

  task automatic run_phase(input string tag, input logic mode, input int h, input int l, input int n);
    int base;
    start_phase(mode, ~mode, h, l);
    base = n_valid;
    drive_cycles(~mode, h, l, n);
    check_val({tag, "_nvalid"}, n_valid - base, n - 1);
  endtask

  initial begin
    int base, base2, target, h, l;
    logic m;
    tick(1);

    // Basic measurement: 600 high / 1400 low.
    run_phase("basic", 1'b0, 600, 1400, 3);

    // Stuck-high line after a measurement.
    base    = n_valid;
    pwm_in  = 1'b1;
    act_cyc = cyc;
    tick(10);
    check_val("stuck_last_valid", n_valid - base, 1);
    target = last_vcyc + TO * P - 2;
    while (cyc < target) tick(1);
    check_val("timeout_early", no_signal, 0);
    tick(1);
    check_val("timeout_set", no_signal, 1);
    check_val("timeout_level", level, 1);
    check_val("timeout_period_hold", period, 1000);
    check_val("timeout_pulse_hold", pulse, 300);
    check_val("timeout_no_valid", n_valid - base, 1);

    // Restart after the stuck line: one full cycle before the next valid.
    pwm_in = 1'b0;
    tick(40);
    base = n_valid;
    drive_cycles(1'b1, 600, 1400, 1);
    check_val("restart_ns_hold", no_signal, 1);
    check_val("restart_no_early_valid", n_valid - base, 0);
    drive_cycles(1'b1, 600, 1400, 1);
    check_val("restart_nvalid", n_valid - base, 1);
    check_val("restart_ns_clear", no_signal, 0);

    // Inverted mode, then same line levels in normal mode.
    run_phase("inv", 1'b1, 600, 1400, 2);
    run_phase("inv_as_normal", 1'b0, 1400, 600, 2);

    // Quantization: 1 sclk high in a 2001 sclk cycle.
    run_phase("quant", 1'b0, 1, 2000, 2);

    // Period saturation.
    run_phase("sat", 1'b0, 1100, 1000, 2);

    // Reset while ACTIVE discards the measurement.
    start_phase(1'b0, 1'b1, 500, 700);
    base = n_valid;
    drive_cycles(1'b1, 500, 700, 2);
    pwm_in  = 1'b1;
    act_cyc = cyc;
    tick(100);
    check_val("midrst_pre_nvalid", n_valid - base, 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs("midrst");
    base2 = n_valid;
    tick(300);
    pwm_in = 1'b0;
    tick(700);
    drive_cycles(1'b1, 500, 700, 2);
    check_val("midrst_nvalid", n_valid - base2, 1);

    // Mode toggle while INACTIVE.
    start_phase(1'b0, 1'b1, 400, 800);
    base = n_valid;
    drive_cycles(1'b1, 400, 800, 2);
    pwm_in  = 1'b1;
    act_cyc = cyc;
    tick(400);
    pwm_in = 1'b0;
    tick(300);
    pwm_mode = 1'b1;
    tick(20);
    check_val("toggle_pre_nvalid", n_valid - base, 2);
    base2  = n_valid;
    pwm_in = 1'b1;
    tick(300);
    exp_per = ticks(300 + 900);
    exp_pul = ticks(300);
    drive_cycles(1'b0, 300, 900, 2);
    check_val("toggle_nvalid", n_valid - base2, 1);

    // Randomized cycles in either polarity.
    for (int k = 0; k < 4; k++) begin
      m = 1'($urandom_range(0, 1));
      h = int'($urandom_range(1, 700));
      l = int'($urandom_range(8, 700));
      run_phase("rand", m, h, l, 3);
    end

    tick(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
